// File: rtl/atm_pkg.sv
// atm_pkg: shared timer state encoding and slow-clock constants for the ATM controller
package atm_pkg;

    localparam int CLK_HZ       = 100_000_000;
    localparam int SLOW_TICK_HZ = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WARN,
        EXPIRED
    } atm_timer_state_t;

endpackage

// File: rtl/rise_detect.sv
// rise_detect: registered rising-edge strobe for a same-domain level signal
// A level already high at reset release is not reported until it has been seen low.
module rise_detect (
    input  logic clk_in,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic tick_d;
    logic armed;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tick_d <= 1'b0;
            armed  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            tick_d <= d;
            armed  <= armed | ~d;
            rise   <= d & ~tick_d & armed;
        end
    end

endmodule

// File: rtl/atm_session_timer.sv
// atm_session_timer: session inactivity timer counting slow ticks into whole seconds with warn/timeout
module atm_session_timer
    import atm_pkg::*;
#(
    parameter int TICKS_PER_SEC = SLOW_TICK_HZ,
    parameter int TIMEOUT_SEC   = 30,
    parameter int WARN_SEC      = 10,
    parameter int SEC_W         = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             tick_in,
    input  logic             start,
    input  logic             activity,
    input  logic             cancel,
    output logic             active,
    output logic             warn,
    output logic             timed_out,
    output logic             expired,
    output logic [SEC_W-1:0] seconds_left
);

    if (WARN_SEC < 1 || WARN_SEC >= TIMEOUT_SEC || TIMEOUT_SEC > (2 ** SEC_W) - 1 || TICKS_PER_SEC < 1) begin : g_bad_params
        $error("atm_session_timer: illegal TICKS_PER_SEC/TIMEOUT_SEC/WARN_SEC/SEC_W");
    end

    localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);
    localparam logic [SEC_W-1:0] SEC_TO   = SEC_W'(TIMEOUT_SEC);
    localparam logic [SEC_W-1:0] SEC_WARN = SEC_W'(WARN_SEC);

    atm_timer_state_t state, nxt_state;
    logic [SEC_W-1:0] sec_cnt, nxt_sec, sec_dec;
    logic [SUB_W-1:0] sub_cnt, nxt_sub;
    logic             tick_rise, live, step, dec, reload, fire;

    rise_detect u_tick (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .d      (tick_in),
        .rise   (tick_rise)
    );

    // cancel > start > activity > tick; a reload also drops any sub-second phase
    always_comb begin
        live      = (state == RUN) || (state == WARN);
        step      = live && tick_rise;
        dec       = step && (sub_cnt == SUB_LAST);
        reload    = start || (activity && live);
        sec_dec   = sec_cnt - 1'b1;
        nxt_sec   = cancel ? '0 : reload ? SEC_TO : dec ? sec_dec : sec_cnt;
        nxt_sub   = (cancel || reload || dec) ? '0 : step ? sub_cnt + 1'b1 : sub_cnt;
        nxt_state = cancel ? IDLE :
                    reload ? RUN :
                    !dec ? state :
                    (sec_dec == '0) ? EXPIRED :
                    (sec_dec <= SEC_WARN) ? WARN : RUN;
        fire      = dec && (sec_dec == '0) && !cancel && !reload;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sec_cnt   <= '0;
            sub_cnt   <= '0;
            active    <= 1'b0;
            warn      <= 1'b0;
            timed_out <= 1'b0;
            expired   <= 1'b0;
        end else begin
            state     <= nxt_state;
            sec_cnt   <= nxt_sec;
            sub_cnt   <= nxt_sub;
            active    <= (nxt_state == RUN) || (nxt_state == WARN);
            warn      <= nxt_state == WARN;
            timed_out <= nxt_state == EXPIRED;
            expired   <= fire;
        end
    end

    assign seconds_left = sec_cnt;

endmodule
